// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants for the framebuffer scan-out.
// Also holds the visible-area predicate used by address and output logic.
package vga_timing_pkg;

   localparam logic [9:0] H_VISIBLE = 10'd640;
   localparam logic [9:0] H_FP      = 10'd16;
   localparam logic [9:0] H_SYNC    = 10'd96;
   localparam logic [9:0] H_BP      = 10'd48;
   localparam logic [9:0] H_TOTAL   = 10'd800;

   localparam logic [9:0] V_VISIBLE = 10'd480;
   localparam logic [9:0] V_FP      = 10'd10;
   localparam logic [9:0] V_SYNC    = 10'd2;
   localparam logic [9:0] V_BP      = 10'd33;
   localparam logic [9:0] V_TOTAL   = 10'd525;

   localparam int FB_W        = 160;
   localparam int FB_H        = 120;
   localparam int SCALE_SHIFT = 2;

   localparam logic [9:0] H_LAST = H_TOTAL - 10'd1;
   localparam logic [9:0] V_LAST = V_TOTAL - 10'd1;
   localparam logic [9:0] HS_BEG = H_VISIBLE + H_FP;
   localparam logic [9:0] HS_END = HS_BEG + H_SYNC - 10'd1;
   localparam logic [9:0] VS_BEG = V_VISIBLE + V_FP;
   localparam logic [9:0] VS_END = VS_BEG + V_SYNC - 10'd1;

   function automatic logic in_visible(input logic [9:0] h,
                                       input logic [9:0] v);
      return (h < H_VISIBLE) && (v < V_VISIBLE);
   endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Pixel-phase divider plus horizontal/vertical raster counters.
// Counters step only on the pixel-enable clock (every other edge).
module vga_sync_counter
   import vga_timing_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   output logic       pe,
   output logic [9:0] hc,
   output logic [9:0] vc
);

   logic ph;

   assign pe = ph;

   always_ff @(posedge clock) begin
      if (reset) begin
         ph <= 1'b0;
         hc <= '0;
         vc <= '0;
      end else begin
         ph <= ~ph;
         if (ph) begin
            if (hc == H_LAST) begin
               hc <= '0;
               vc <= (vc == V_LAST) ? '0 : vc + 10'd1;
            end else begin
               hc <= hc + 10'd1;
            end
         end
      end
   end

endmodule

// File: rtl/vga_scanout.sv
// VGA scan-out of a 160x120 framebuffer, each stored pixel shown 4x4.
// Outputs lag the counters by one pixel to cover the 1-clock RAM read.
module vga_scanout
   import vga_timing_pkg::*;
#(
   parameter int ADDR_W   = 15,
   parameter int COLOUR_W = 3
) (
   input  logic                clock,
   input  logic                reset,
   output logic [ADDR_W-1:0]   rd_addr,
   input  logic [COLOUR_W-1:0] rd_data,
   output logic [7:0]          VGA_R,
   output logic [7:0]          VGA_G,
   output logic [7:0]          VGA_B,
   output logic                VGA_HS,
   output logic                VGA_VS,
   output logic                VGA_BLANK_N,
   output logic                VGA_SYNC_N,
   output logic                VGA_CLK,
   output logic                vblank,
   output logic                vblank_tick
);

   logic              pe;
   logic [9:0]        hc;
   logic [9:0]        vc;
   logic              vis;
   logic [7:0]        x;
   logic [6:0]        y;
   logic [ADDR_W-1:0] xa;
   logic [ADDR_W-1:0] ya;

   vga_sync_counter u_cnt (
      .clock (clock),
      .reset (reset),
      .pe    (pe),
      .hc    (hc),
      .vc    (vc)
   );

   assign vis = in_visible(hc, vc);
   assign x   = hc[9:SCALE_SHIFT];
   assign y   = vc[8:SCALE_SHIFT];
   assign xa  = ADDR_W'(x);
   assign ya  = ADDR_W'(y);

   // y*160 as two shifts keeps the adder narrow
   assign rd_addr = vis ? (ya << 7) + (ya << 5) + xa : '0;

   assign VGA_CLK    = pe;
   assign VGA_SYNC_N = 1'b1;
   assign vblank     = (vc >= V_VISIBLE);

   always_ff @(posedge clock) begin
      if (reset) begin
         VGA_R       <= '0;
         VGA_G       <= '0;
         VGA_B       <= '0;
         VGA_HS      <= 1'b1;
         VGA_VS      <= 1'b1;
         VGA_BLANK_N <= 1'b0;
         vblank_tick <= 1'b0;
      end else begin
         vblank_tick <= pe && (hc == H_LAST)
                        && (vc == V_VISIBLE - 10'd1);
         if (pe) begin
            VGA_BLANK_N <= vis;
            VGA_HS      <= ~((hc >= HS_BEG) && (hc <= HS_END));
            VGA_VS      <= ~((vc >= VS_BEG) && (vc <= VS_END));
            VGA_R       <= vis ? {8{rd_data[2]}} : 8'd0;
            VGA_G       <= vis ? {8{rd_data[1]}} : 8'd0;
            VGA_B       <= vis ? {8{rd_data[0]}} : 8'd0;
         end
      end
   end

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout with a 1-clock model framebuffer.
// Vertical positions are reached by depositing the row counter.
module tb_vga_scanout;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [14:0] rd_addr;
   logic [2:0]  rd_data = 3'd0;
   logic [7:0]  VGA_R, VGA_G, VGA_B;
   logic        VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK;
   logic        vblank, vblank_tick;

   int cyc = 0;
   int t0 = 0;
   int n_chk = 0;
   int n_fail = 0;

   vga_scanout dut (
      .clock       (clock),
      .reset       (reset),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .VGA_R       (VGA_R),
      .VGA_G       (VGA_G),
      .VGA_B       (VGA_B),
      .VGA_HS      (VGA_HS),
      .VGA_VS      (VGA_VS),
      .VGA_BLANK_N (VGA_BLANK_N),
      .VGA_SYNC_N  (VGA_SYNC_N),
      .VGA_CLK     (VGA_CLK),
      .vblank      (vblank),
      .vblank_tick (vblank_tick)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      cyc     <= cyc + 1;
      rd_data <= rd_addr[2:0];
   end

   // wait until the negedge following edge n after reset release
   task automatic wait_rel(input int n);
      while (cyc - t0 < n) @(negedge clock);
   endtask

   function automatic logic [24:0] pix(input logic [2:0] c);
      return {1'b1, {8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
   endfunction

   task automatic test_reset;
      logic [31:0] got;
      repeat (3) @(negedge clock);
      got = {VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R[0],
             VGA_G[0], VGA_B[0], vblank, vblank_tick, VGA_SYNC_N,
             7'd0, rd_addr};
      n_chk++;
      if (got !== {10'b0110000001, 7'd0, 15'd0}) begin
         n_fail++;
         $display("FAIL reset_state got %h want %h", got,
                  {10'b0110000001, 7'd0, 15'd0});
      end
      reset = 1'b0;
      t0 = cyc;
      wait_rel(1);
      n_chk++;
      if ({VGA_CLK, VGA_BLANK_N} !== 2'b10) begin
         n_fail++;
         $display("FAIL edge1 clk/blank got %b want 10",
                  {VGA_CLK, VGA_BLANK_N});
      end
      wait_rel(2);
      n_chk++;
      if ({VGA_CLK, VGA_BLANK_N, VGA_R, VGA_G, VGA_B}
          !== {2'b01, 24'd0}) begin
         n_fail++;
         $display("FAIL first_pixel got %b %b rgb %h want 01 000000",
                  VGA_CLK, VGA_BLANK_N, {VGA_R, VGA_G, VGA_B});
      end
   endtask

   task automatic test_line0;
      int hl[7] = '{0, 4, 8, 20, 28, 31, 32};
      logic [2:0] c;
      for (int i = 0; i < 7; i++) begin
         wait_rel(2 + 2 * hl[i]);
         c = 3'((hl[i] / 4) % 8);
         n_chk++;
         if ({VGA_BLANK_N, VGA_R, VGA_G, VGA_B} !== pix(c)) begin
            n_fail++;
            $display("FAIL line0_h%0d got %h want %h", hl[i],
                     {VGA_BLANK_N, VGA_R, VGA_G, VGA_B}, pix(c));
         end
      end
      wait_rel(1272);
      n_chk++;
      if (rd_addr !== 15'd159) begin
         n_fail++;
         $display("FAIL addr_h636 got %0d want 159", rd_addr);
      end
      wait_rel(1274);
      n_chk++;
      if ({VGA_BLANK_N, VGA_R, VGA_G, VGA_B} !== pix(3'd7)) begin
         n_fail++;
         $display("FAIL line0_h636 got %h want %h",
                  {VGA_BLANK_N, VGA_R, VGA_G, VGA_B}, pix(3'd7));
      end
      wait_rel(1280);
      n_chk++;
      if (rd_addr !== 15'd0) begin
         n_fail++;
         $display("FAIL addr_hblank got %0d want 0", rd_addr);
      end
      wait_rel(1282);
      n_chk++;
      if ({VGA_BLANK_N, VGA_R, VGA_G, VGA_B} !== 25'd0) begin
         n_fail++;
         $display("FAIL blank_h640 got %h want 0",
                  {VGA_BLANK_N, VGA_R, VGA_G, VGA_B});
      end
   endtask

   task automatic test_hsync;
      int low = 0;
      int first = -1;
      int vs_low = 0;
      for (int r = 1602; r <= 3201; r++) begin
         wait_rel(r);
         if (!VGA_HS) begin
            low++;
            if (first < 0) first = r;
         end
         if (!VGA_VS) vs_low++;
      end
      n_chk++;
      if (low !== 192) begin
         n_fail++;
         $display("FAIL hs_width got %0d want 192", low);
      end
      n_chk++;
      if (first - 1602 !== 1312) begin
         n_fail++;
         $display("FAIL hs_start got %0d want 1312", first - 1602);
      end
      n_chk++;
      if (vs_low !== 0) begin
         n_fail++;
         $display("FAIL vs_line1 got %0d want 0", vs_low);
      end
   endtask

   task automatic test_rows;
      int rr[4] = '{6400, 8016, 9800, 12478};
      int ra[4] = '{160, 162, 185, 319};
      for (int i = 0; i < 4; i++) begin
         wait_rel(rr[i]);
         n_chk++;
         if (rd_addr !== 15'(ra[i])) begin
            n_fail++;
            $display("FAIL row_addr%0d got %0d want %0d", i,
                     rd_addr, ra[i]);
         end
         if (i == 0) begin
            wait_rel(6410);
            n_chk++;
            if ({VGA_BLANK_N, VGA_R, VGA_G, VGA_B} !== pix(3'd1)) begin
               n_fail++;
               $display("FAIL row4_h4 got %h want %h",
                        {VGA_BLANK_N, VGA_R, VGA_G, VGA_B}, pix(3'd1));
            end
         end
      end
   endtask

   task automatic test_vertical;
      int ticks = 0;
      int tick_at = -1;
      int vs_low = 0;
      int vs_first = -1;
      wait_rel(12802);
      force dut.u_cnt.vc = 10'd478;
      #1 release dut.u_cnt.vc;
      wait_rel(15678);
      n_chk++;
      if ({vblank, rd_addr} !== {1'b0, 15'd19199}) begin
         n_fail++;
         $display("FAIL addr_last got %b %0d want 0 19199",
                  vblank, rd_addr);
      end
      wait_rel(15680);
      n_chk++;
      if ({VGA_BLANK_N, VGA_R, VGA_G, VGA_B} !== pix(3'd7)) begin
         n_fail++;
         $display("FAIL pix_last got %h want %h",
                  {VGA_BLANK_N, VGA_R, VGA_G, VGA_B}, pix(3'd7));
      end
      for (int r = 15681; r <= 35300; r++) begin
         wait_rel(r);
         if (vblank_tick) begin
            ticks++;
            tick_at = r;
         end
         if (!VGA_VS) begin
            vs_low++;
            if (vs_first < 0) vs_first = r;
         end
         if (r == 15999 || r == 16000) begin
            n_chk++;
            if (vblank !== (r == 16000)) begin
               n_fail++;
               $display("FAIL vblank_r%0d got %b want %b", r,
                        vblank, r == 16000);
            end
         end
      end
      n_chk++;
      if ({ticks, tick_at} !== {32'd1, 32'd16000}) begin
         n_fail++;
         $display("FAIL tick got %0d at %0d want 1 at 16000",
                  ticks, tick_at);
      end
      n_chk++;
      if ({vs_low, vs_first} !== {32'd3200, 32'd32002}) begin
         n_fail++;
         $display("FAIL vsync got %0d from %0d want 3200 from 32002",
                  vs_low, vs_first);
      end
      wait_rel(35302);
      force dut.u_cnt.vc = 10'd523;
      #1 release dut.u_cnt.vc;
      wait_rel(38399);
      n_chk++;
      if (vblank !== 1'b1) begin
         n_fail++;
         $display("FAIL vblank_end got %b want 1", vblank);
      end
      wait_rel(38400);
      n_chk++;
      if ({vblank, VGA_BLANK_N} !== 2'b00) begin
         n_fail++;
         $display("FAIL frame_wrap got %b want 00",
                  {vblank, VGA_BLANK_N});
      end
      wait_rel(38402);
      n_chk++;
      if (VGA_BLANK_N !== 1'b1) begin
         n_fail++;
         $display("FAIL frame_restart got %b want 1", VGA_BLANK_N);
      end
   endtask

   task automatic test_mid_reset;
      logic [31:0] got;
      wait_rel(38410);
      force dut.u_cnt.vc = 10'd199;
      #1 release dut.u_cnt.vc;
      wait_rel(40600);
      n_chk++;
      if (rd_addr !== 15'd8075) begin
         n_fail++;
         $display("FAIL addr_300_200 got %0d want 8075", rd_addr);
      end
      reset = 1'b1;
      wait_rel(40601);
      got = {VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, |VGA_R,
             |VGA_G, |VGA_B, vblank, vblank_tick, VGA_SYNC_N,
             7'd0, rd_addr};
      n_chk++;
      if (got !== {10'b0110000001, 7'd0, 15'd0}) begin
         n_fail++;
         $display("FAIL mid_reset got %h want %h", got,
                  {10'b0110000001, 7'd0, 15'd0});
      end
      reset = 1'b0;
      t0 = cyc;
      wait_rel(1);
      n_chk++;
      if ({VGA_CLK, VGA_BLANK_N} !== 2'b10) begin
         n_fail++;
         $display("FAIL rst_edge1 got %b want 10",
                  {VGA_CLK, VGA_BLANK_N});
      end
      wait_rel(2);
      n_chk++;
      if ({VGA_BLANK_N, VGA_R, VGA_G, VGA_B} !== pix(3'd0)) begin
         n_fail++;
         $display("FAIL rst_pixel0 got %h want %h",
                  {VGA_BLANK_N, VGA_R, VGA_G, VGA_B}, pix(3'd0));
      end
      wait_rel(10);
      n_chk++;
      if ({VGA_BLANK_N, VGA_R, VGA_G, VGA_B, vblank}
          !== {pix(3'd1), 1'b0}) begin
         n_fail++;
         $display("FAIL rst_pixel4 got %h want %h",
                  {VGA_BLANK_N, VGA_R, VGA_G, VGA_B, vblank},
                  {pix(3'd1), 1'b0});
      end
      wait_rel(1314);
      n_chk++;
      if (VGA_HS !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_hs got %b want 0", VGA_HS);
      end
   endtask

   initial begin
      test_reset;
      test_line0;
      test_hsync;
      test_rows;
      test_vertical;
      test_mid_reset;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_scanout.md
# vga_scanout

Read side of the 160x120 framebuffer that the drawing FSMs write through `plot`/`x`/`y`/`colour`. The block generates 640x480@60 Hz VGA timing from the 50 MHz board clock. It fetches each displayed pixel from a synchronous framebuffer read port, replicating every stored pixel 4x4. It drives the DAC pins and gives game logic a once-per-frame vertical-blank tick, so animation steps can be paced to the display rather than to a free-running divider.

## Interface
Parameters:
- `ADDR_W`, 15: framebuffer read address width (19200 entries).
- `COLOUR_W`, 3: stored colour width, {R,G,B} one bit each.

Ports:
- `clock`  in  1  50 MHz system clock.
- `reset`  in  1  synchronous, active-high reset.
- `rd_addr`  out  ADDR_W  framebuffer read address, y*160+x.
- `rd_data`  in  COLOUR_W  framebuffer data; valid one clock after `rd_addr` is sampled.
- `VGA_R`, `VGA_G`, `VGA_B`  out  8 each  DAC channels.
- `VGA_HS`, `VGA_VS`  out  1 each  syncs, active-low.
- `VGA_BLANK_N`  out  1  low outside the visible area.
- `VGA_SYNC_N`  out  1  constant 1.
- `VGA_CLK`  out  1  25 MHz pixel clock to the DAC.
- `vblank`  out  1  high while the registered vertical count is 480 or more.
- `vblank_tick`  out  1  one-clock pulse on entry to vertical blank.

## Operation
Pixel phase:
- 1-bit `ph` toggles every clock.
- Pixel enable `pe = ph`.
- Counters and output registers change only on edges where `pe` = 1.

Horizontal counter `hc`:
- 0..799.
- Visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.

Vertical counter `vc`:
- 0..524.
- Visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
- Advances only when `hc` wraps 799 to 0.
- Both counters wrap at (799,524) to (0,0).

Address generation:
- Combinational from registered `hc`/`vc`.
- x = hc[9:2], y = vc[8:2].
- `rd_addr` = (y<<7)+(y<<5)+x, computed in 15 bits with no overflow (max 19199).
- Outside the visible area, `rd_addr` = 0.

Output stage, captured on each `pe` edge using the pre-increment `hc`/`vc`:
- `VGA_BLANK_N` = visible.
- `VGA_HS` = ~(656 ≤ hc ≤ 751).
- `VGA_VS` = ~(490 ≤ vc ≤ 491).
- `VGA_R` = {8{rd_data[2]}}, `VGA_G` = {8{rd_data[1]}}, `VGA_B` = {8{rd_data[0]}}.
- When not visible, all channels = 0.

Blank flags:
- `vblank` = (vc ≥ 480), taken from the counter register.
- `vblank_tick` = 1 for exactly the clock after the `pe` edge where (hc,vc) advanced from (799,479) to (0,480).

Reset:
- `ph`=0, `hc`=0, `vc`=0.
- RGB=0, `VGA_HS`=1, `VGA_VS`=1, `VGA_BLANK_N`=0.
- `vblank`=0, `vblank_tick`=0, `VGA_CLK`=0.
- Reset asserted mid-frame returns to these values on the next edge. The first frame after release starts at (0,0) with no partial-line artefacts.

## Timing
- `VGA_CLK` = `ph`, registered. Outputs change on the edge that drops `VGA_CLK`, so the DAC samples on the rising edge, mid-window.
- Fetch pipeline:
  - Edge N (`pe`=1): counters move to (h,v) and `rd_addr` becomes valid.
  - Edge N+1: the RAM samples `rd_addr`.
  - Edge N+2 (`pe`=1): outputs register `rd_data` together with the sync/blank of (h,v).
- Latency from counter value to pin: 2 clocks (one pixel). Sync, blank and colour are always aligned.
- Requirement on the framebuffer: read latency of exactly 1 clock, with no stall.
- Frame = 800*525*2 = 840000 clocks. Line = 1600 clocks.

## Structure
- Package `vga_timing_pkg`: H_VISIBLE=640, H_FP=16, H_SYNC=96, H_BP=48, H_TOTAL=800, V_VISIBLE=480, V_FP=10, V_SYNC=2, V_BP=33, V_TOTAL=525, FB_W=160, FB_H=120, SCALE_SHIFT=2.
- One sub-module, `vga_sync_counter`: phase toggle plus `hc`/`vc` counters, outputting `pe`, `hc`, `vc`.
- The top contains address generation, the output registers and the blank-tick logic.

## Test plan
- Reset release → after 2 clocks `VGA_CLK` toggles; first visible pixel (`VGA_BLANK_N`=1) is on the clock after the second `pe` edge; `rd_addr`=0 at (0,0).
- Model RAM containing addr → addr[2:0]; sample line 0 → colour changes every 8 clocks; addr 159 appears at hc 636..639; `rd_addr`=0 during blank.
- Count clocks → `VGA_HS` low for 192 clocks per 1600-clock line, starting 1312 clocks after the line's first visible pixel on the pins.
- Count lines → `VGA_VS` low for 2 lines; `vblank_tick` pulses exactly once per 840000 clocks, 768000 clocks after frame start.
- vc 4..7 → `rd_addr` = 160+x on all four lines; at (639,479) → `rd_addr` = 19199.
- Assert `reset` at hc=300, vc=200 for 1 clock → all outputs at reset values next clock; the frame restarts at (0,0) and the next `vblank_tick` arrives 768000 clocks after release.
